// File: rtl/fixed_sqrt_pkg.sv
// Shared types and elaboration helpers for the handshaked fixed-point square root.
package fixed_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int iters(input int width, input int frac);
    return (width + frac) / 32'sd2;
  endfunction

  function automatic bit width_ok(input int width, input int frac);
    return ((width + frac) % 32'sd2 == 32'sd0) && (frac <= width) && (frac >= 32'sd0);
  endfunction

  function automatic bit steps_ok(input int width, input int frac, input int steps);
    return (steps > 32'sd0) && (iters(width, frac) % steps == 32'sd0);
  endfunction

endpackage

// File: rtl/fixed_sqrt_step.sv
// One combinational digit-recurrence step: retires a single root bit from two radicand bits.
module fixed_sqrt_step #(
  parameter int ITERS = 24
) (
  input  logic [ITERS+1:0] acc,
  input  logic [ITERS-1:0] root,
  input  logic [1:0]       pair,
  output logic [ITERS+1:0] next_acc,
  output logic [ITERS-1:0] next_root
);

  localparam int AW = ITERS + 2;

  logic [AW-1:0] shifted_s;
  logic [AW:0]   diff_s;
  logic          fits_s;

  // Trial subtraction; the partial remainder never exceeds 2*root, so AW bits suffice.
  always_comb begin
    shifted_s = AW'({acc, pair});
    diff_s    = {1'b0, shifted_s} - {1'b0, root, 2'b01};
    fits_s    = ~diff_s[AW];
    next_root = ITERS'({root, fits_s});
    if (fits_s) begin
      next_acc = diff_s[AW-1:0];
    end else begin
      next_acc = shifted_s;
    end
  end

endmodule

// File: rtl/fixed_sqrt_hs.sv
// Unsigned fixed-point sqrt with valid/ready on both sides, STEPS_PER_CYCLE root bits per clock.
// Define FIXED_SQRT_REMAINDER_EN to expose the final remainder on out_rem.
module fixed_sqrt_hs
  import fixed_sqrt_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int FRAC_WIDTH      = 16,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
`ifdef FIXED_SQRT_REMAINDER_EN
  output logic [(WIDTH+FRAC_WIDTH)/2:0]     out_rem,
`endif
  output logic [WIDTH-1:0]                  out_data
);

  localparam int ITERS = iters(WIDTH, FRAC_WIDTH);
  localparam int RW    = WIDTH + FRAC_WIDTH;
  localparam int AW    = ITERS + 2;
  localparam int N     = ITERS / STEPS_PER_CYCLE;
  localparam int CW    = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!width_ok(WIDTH, FRAC_WIDTH)) begin : g_bad_width
    $error("fixed_sqrt_hs: WIDTH+FRAC_WIDTH must be even and FRAC_WIDTH <= WIDTH");
  end
  if (!steps_ok(WIDTH, FRAC_WIDTH, STEPS_PER_CYCLE)) begin : g_bad_steps
    $error("fixed_sqrt_hs: STEPS_PER_CYCLE must divide (WIDTH+FRAC_WIDTH)/2");
  end

  state_t            state_r, state_nx;
  logic [RW-1:0]     rad_r;
  logic [AW-1:0]     acc_r;
  logic [ITERS-1:0]  root_r;
  logic [CW-1:0]     cnt_r;
  logic [WIDTH-1:0]  out_data_r;
  logic              accept_s;

  logic [AW-1:0]     acc_c  [STEPS_PER_CYCLE+1];
  logic [ITERS-1:0]  root_c [STEPS_PER_CYCLE+1];

  assign acc_c[0]  = acc_r;
  assign root_c[0] = root_r;

  // Chain of recurrence steps; step i consumes the i-th radicand bit pair from the top.
  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    fixed_sqrt_step #(.ITERS(ITERS)) u_step (
      .acc       (acc_c[i]),
      .root      (root_c[i]),
      .pair      (rad_r[RW-1-2*i -: 2]),
      .next_acc  (acc_c[i+1]),
      .next_root (root_c[i+1])
    );
  end

  assign in_ready  = !reset && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
  assign out_valid = (state_r == DONE);
  assign out_data  = out_data_r;
  assign accept_s  = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic; DONE with out_ready and in_valid restarts directly into BUSY.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nx = BUSY;
        else          state_nx = IDLE;
      end
      BUSY: begin
        if (cnt_r == LAST) state_nx = DONE;
        else               state_nx = BUSY;
      end
      DONE: begin
        if (out_ready) state_nx = in_valid ? BUSY : IDLE;
        else           state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate while BUSY, capture the root on the final edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rad_r      <= '0;
      acc_r      <= '0;
      root_r     <= '0;
      cnt_r      <= '0;
      out_data_r <= '0;
    end else if (accept_s) begin
      rad_r  <= RW'(in_data) << FRAC_WIDTH;
      acc_r  <= '0;
      root_r <= '0;
      cnt_r  <= '0;
    end else if (state_r == BUSY) begin
      rad_r  <= rad_r << (2 * STEPS_PER_CYCLE);
      acc_r  <= acc_c[STEPS_PER_CYCLE];
      root_r <= root_c[STEPS_PER_CYCLE];
      cnt_r  <= cnt_r + CW'(1'b1);
      if (cnt_r == LAST) begin
        out_data_r <= WIDTH'(root_c[STEPS_PER_CYCLE]);
      end
    end
  end

`ifdef FIXED_SQRT_REMAINDER_EN
  logic [ITERS:0] out_rem_r;

  // Remainder is captured alongside the root and obeys the same hold rules.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_rem_r <= '0;
    end else if (!accept_s && (state_r == BUSY) && (cnt_r == LAST)) begin
      out_rem_r <= acc_c[STEPS_PER_CYCLE][ITERS:0];
    end
  end

  assign out_rem = out_rem_r;
`endif

endmodule

// File: tb/tb_fixed_sqrt_hs.sv
// Randomised, self-checking bench for fixed_sqrt_hs (STEPS_PER_CYCLE = 1 and 4 instances).
module tb_fixed_sqrt_hs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_valid4 = 1'b0;
  logic        out_ready = 1'b0, out_ready4 = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_ready, in_ready4, out_valid, out_valid4;
  logic [31:0] out_data, out_data4;
`ifdef FIXED_SQRT_REMAINDER_EN
  logic [24:0] out_rem, out_rem4;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fixed_sqrt_hs #(.WIDTH(32), .FRAC_WIDTH(16), .STEPS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef FIXED_SQRT_REMAINDER_EN
    .out_rem(out_rem),
`endif
    .out_data(out_data)
  );

  fixed_sqrt_hs #(.WIDTH(32), .FRAC_WIDTH(16), .STEPS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready4),
`ifdef FIXED_SQRT_REMAINDER_EN
    .out_rem(out_rem4),
`endif
    .out_data(out_data4)
  );

  // Reference: largest r with r*r <= in * 2^16, found greedily bit by bit in 64-bit arithmetic.
  function automatic logic [31:0] model_sqrt(input logic [31:0] v);
    logic [63:0] x, r, t;
    x = {16'h0, v, 16'h0};
    r = 64'd0;
    for (int b = 24; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r[31:0];
  endfunction

  function automatic logic [63:0] model_rem(input logic [31:0] v);
    logic [63:0] x, r;
    x = {16'h0, v, 16'h0};
    r = {32'h0, model_sqrt(v)};
    return x - r * r;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] k;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $urandom_range(0, 255);
      2: return 32'hFFFF_FFFF - $urandom_range(0, 15);
      default: begin
        k = $urandom_range(0, 65535);
        return k * k;
      end
    endcase
  endfunction

  // Single operation on an idle DUT; caller is #1 after a rising edge. Result is held, then consumed.
  task automatic do_op(input logic [31:0] d, input bit use4,
                       output logic [31:0] res, output logic [63:0] rem, output int lat);
    if (use4) begin in_valid4 = 1'b1; out_ready4 = 1'b0; end
    else      begin in_valid  = 1'b1; out_ready  = 1'b0; end
    in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    lat = 0;
    while (!(use4 ? out_valid4 : out_valid) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = use4 ? out_data4 : out_data;
    rem = 64'd0;
`ifdef FIXED_SQRT_REMAINDER_EN
    rem = use4 ? {39'd0, out_rem4} : {39'd0, out_rem};
`endif
    if (use4) out_ready4 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h0004_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: out_valid=%b out_data=%h in_ready=%b, expected 0 0 0", out_valid, out_data, in_ready);
    end
    tests++;
    if (out_valid4 !== 1'b0 || out_data4 !== 32'h0 || in_ready4 !== 1'b0) begin
      fails++;
      $display("FAIL reset_state4: out_valid=%b out_data=%h in_ready=%b, expected 0 0 0", out_valid4, out_data4, in_ready4);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] vin  [5] = '{32'h0004_0000, 32'h0002_0000, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] vexp [5] = '{32'h0002_0000, 32'h0001_6A09, 32'h0000_0100, 32'h0000_0000, 32'h00FF_FFFF};
    logic [31:0] res;
    logic [63:0] rem;
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(vin[i], 1'b0, res, rem, lat);
      tests++;
      if (res !== vexp[i]) begin
        fails++;
        $display("FAIL basic_data[%0d]: got %h expected %h", i, res, vexp[i]);
      end
      tests++;
      if (lat !== 24) begin
        fails++;
        $display("FAIL basic_latency[%0d]: got %0d expected 24", i, lat);
      end
`ifdef FIXED_SQRT_REMAINDER_EN
      tests++;
      if (rem !== model_rem(vin[i])) begin
        fails++;
        $display("FAIL basic_rem[%0d]: got %h expected %h", i, rem, model_rem(vin[i]));
      end
`endif
    end
  endtask

  task automatic test_steps4();
    logic [31:0] vin  [2] = '{32'hFFFF_FFFF, 32'h0004_0000};
    logic [31:0] vexp [2] = '{32'h00FF_FFFF, 32'h0002_0000};
    logic [31:0] res;
    logic [63:0] rem;
    int lat;
    for (int i = 0; i < 2; i++) begin
      do_op(vin[i], 1'b1, res, rem, lat);
      tests++;
      if (res !== vexp[i]) begin
        fails++;
        $display("FAIL steps4_data[%0d]: got %h expected %h", i, res, vexp[i]);
      end
      tests++;
      if (lat !== 6) begin
        fails++;
        $display("FAIL steps4_latency[%0d]: got %0d expected 6", i, lat);
      end
`ifdef FIXED_SQRT_REMAINDER_EN
      tests++;
      if (rem !== model_rem(vin[i])) begin
        fails++;
        $display("FAIL steps4_rem[%0d]: got %h expected %h", i, rem, model_rem(vin[i]));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h0009_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 32'h0003_0000 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold[%0d]: out_valid=%b out_data=%h in_ready=%b, expected 1 00030000 0", c, out_valid, out_data, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = 32'h0019_0000; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_consumed: out_valid=%b expected 0", out_valid);
    end
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    tests++;
    if (lat !== 24 || out_data !== 32'h0005_0000) begin
      fails++;
      $display("FAIL b2b_result: latency %0d data %h, expected 24 00050000", lat, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic [63:0] rem;
    int lat;
    int seen = 0;
    in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h1234_5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      fails++;
      $display("FAIL midreset_state: out_valid=%b out_data=%h, expected 0 0", out_valid, out_data);
    end
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL midreset_stale: saw out_valid %0d cycles, expected 0", seen);
    end
    do_op(32'h0010_0000, 1'b0, res, rem, lat);
    tests++;
    if (res !== 32'h0004_0000 || lat !== 24) begin
      fails++;
      $display("FAIL midreset_next: data %h latency %0d, expected 00040000 24", res, lat);
    end
  endtask

  task automatic test_random(input bit use4, input int nops, input int budget);
    logic [31:0] q[$];
    logic [31:0] cur = 32'h0;
    logic [31:0] exp_v;
    bit have = 1'b0;
    int sent = 0, got = 0, cyc = 0;
    while ((sent < nops || got < sent) && cyc < budget) begin
      if (!have && sent < nops && $urandom_range(0, 3) != 0) begin
        cur = pick_operand();
        have = 1'b1;
      end
      if (use4) begin in_valid4 = have; out_ready4 = ($urandom_range(0, 2) != 0); end
      else      begin in_valid  = have; out_ready  = ($urandom_range(0, 2) != 0); end
      in_data = have ? cur : $urandom;
      #1;
      if ((use4 ? (in_valid4 && in_ready4) : (in_valid && in_ready))) begin
        q.push_back(model_sqrt(cur));
        sent++;
        have = 1'b0;
      end
      if ((use4 ? (out_valid4 && out_ready4) : (out_valid && out_ready))) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL random%0d_extra: unexpected result %h", use4 ? 4 : 1, use4 ? out_data4 : out_data);
        end else begin
          exp_v = q.pop_front();
          got++;
          if ((use4 ? out_data4 : out_data) !== exp_v) begin
            fails++;
            $display("FAIL random%0d_data[%0d]: got %h expected %h", use4 ? 4 : 1, got, use4 ? out_data4 : out_data, exp_v);
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0; out_ready4 = 1'b0;
    tests++;
    if (got !== nops || q.size() !== 0) begin
      fails++;
      $display("FAIL random%0d_count: got %0d results, pending %0d, expected %0d and 0", use4 ? 4 : 1, got, q.size(), nops);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_steps4();
    test_back_to_back();
    test_reset_mid();
    test_random(1'b0, 300, 30000);
    test_random(1'b1, 1000, 30000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
